// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: miss FSM states and fixed AXI read-burst attributes.
package cc_pkg;

   typedef enum logic {
      StIdle  = 1'b0,
      StIssue = 1'b1
   } cc_state_e;

   // AXI burst-type encodings.
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // A line refill is 8 beats of 8 bytes, wrapping from the critical doubleword.
   localparam logic [3:0] CC_BURST_LEN = 4'd7;
   localparam logic [2:0] CC_BEAT_SIZE = 3'd3;

endpackage

// File: rtl/cc_miss_req_ctrl.sv
// Miss request controller: captures one miss at a time, issues a WRAP read burst on AR,
// records the miss address in the refill FIFO and tracks in-flight bursts.
module cc_miss_req_ctrl
   import cc_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_req_i,
   input  logic [31:0] miss_addr_i,
   output logic        miss_ack_o,
   output logic        mem_arvalid_o,
   input  logic        mem_arready_i,
   output logic [31:0] mem_araddr_o,
   output logic [3:0]  mem_arlen_o,
   output logic [2:0]  mem_arsize_o,
   output logic [1:0]  mem_arburst_o,
   input  logic        mem_rvalid_i,
   input  logic        mem_rready_i,
   input  logic        mem_rlast_i,
   input  logic        miss_addr_fifo_full_i,
   output logic        miss_addr_fifo_wren_o,
   output logic [31:0] miss_addr_fifo_wdata_o,
   output logic [2:0]  outstanding_o,
   output logic        busy_o
);

   localparam logic [2:0] MaxOut = 3'(MAX_OUTSTANDING);

   cc_state_e   state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  outstanding_q, outstanding_d;
   logic        capture;
   logic        ar_hs;
   logic        r_done;

   assign r_done = mem_rvalid_i & mem_rready_i & mem_rlast_i;

   // FSM next state: capture a miss in IDLE, hold AR in ISSUE until accepted.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      capture = 1'b0;
      ar_hs   = 1'b0;
      case (state_q)
         StIdle: begin
            if (miss_req_i && (outstanding_q < MaxOut) && !miss_addr_fifo_full_i) begin
               capture = 1'b1;
               addr_d  = miss_addr_i;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (mem_arready_i) begin
               ar_hs   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // In-flight burst count: +1 per AR handshake, -1 per last R beat, saturating at zero.
   always_comb begin
      outstanding_d = outstanding_q;
      if (ar_hs && !r_done) begin
         outstanding_d = outstanding_q + 3'd1;
      end else if (r_done && !ar_hs && (outstanding_q != 3'd0)) begin
         outstanding_d = outstanding_q - 3'd1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         outstanding_q <= outstanding_d;
      end
   end

   // Ack and push are qualified by rst_n so a handshake seen during reset leaves no trace.
   assign miss_ack_o             = rst_n & capture;
   assign miss_addr_fifo_wren_o  = rst_n & ar_hs;
   assign miss_addr_fifo_wdata_o = addr_q;

   // AR channel driven purely from registers; address aligned to the critical doubleword.
   assign mem_arvalid_o = (state_q == StIssue);
   assign mem_araddr_o  = {addr_q[31:3], 3'b000};
   assign mem_arlen_o   = CC_BURST_LEN;
   assign mem_arsize_o  = CC_BEAT_SIZE;
   assign mem_arburst_o = BURST_WRAP;

   assign outstanding_o = outstanding_q;
   assign busy_o        = (state_q != StIdle) || (outstanding_q != 3'd0);

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// Self-checking bench for cc_miss_req_ctrl: table of per-cycle vectors plus a back-to-back
// sequence that fills the outstanding limit.
module tb_cc_miss_req_ctrl;

   logic        clk;
   logic        rst_n;
   logic        miss_req;
   logic [31:0] miss_addr;
   logic        miss_ack_o;
   logic        mem_arvalid_o;
   logic        mem_arready;
   logic [31:0] mem_araddr_o;
   logic [3:0]  mem_arlen_o;
   logic [2:0]  mem_arsize_o;
   logic [1:0]  mem_arburst_o;
   logic        mem_rvalid;
   logic        mem_rready;
   logic        mem_rlast;
   logic        fifo_full;
   logic        miss_addr_fifo_wren_o;
   logic [31:0] miss_addr_fifo_wdata_o;
   logic [2:0]  outstanding_o;
   logic        busy_o;

   int n_asserts = 0;
   int n_fail    = 0;

   logic [31:0] push_q[$];

   cc_miss_req_ctrl #(
      .MAX_OUTSTANDING(4)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .miss_req_i             (miss_req),
      .miss_addr_i            (miss_addr),
      .miss_ack_o             (miss_ack_o),
      .mem_arvalid_o          (mem_arvalid_o),
      .mem_arready_i          (mem_arready),
      .mem_araddr_o           (mem_araddr_o),
      .mem_arlen_o            (mem_arlen_o),
      .mem_arsize_o           (mem_arsize_o),
      .mem_arburst_o          (mem_arburst_o),
      .mem_rvalid_i           (mem_rvalid),
      .mem_rready_i           (mem_rready),
      .mem_rlast_i            (mem_rlast),
      .miss_addr_fifo_full_i  (fifo_full),
      .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
      .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
      .outstanding_o          (outstanding_o),
      .busy_o                 (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   // Log FIFO pushes and check the fixed AR attributes whenever AR is presented.
   always @(negedge clk) begin
      if (miss_addr_fifo_wren_o === 1'b1) push_q.push_back(miss_addr_fifo_wdata_o);
      if (mem_arvalid_o === 1'b1) begin
         check_eq("ar attrs", {23'd0, mem_arlen_o, mem_arsize_o, mem_arburst_o},
                  {23'd0, 4'd7, 3'd3, 2'b10});
      end
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        rst_n;
      logic        req;
      logic [31:0] addr;
      logic        rdy;
      logic        rl;
      logic        full;
      logic        ack;
      logic        av;
      logic [31:0] araddr;
      logic        wr;
      logic [31:0] wdata;
      logic [2:0]  out;
      logic        busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic q, input logic [31:0] a,
                               input logic rdy, input logic rl, input logic f,
                               input logic ack, input logic av, input logic [31:0] ara,
                               input logic wr, input logic [31:0] wd, input logic [2:0] out,
                               input logic busy);
      vec_t v;
      v.rst_n = r;   v.req = q;   v.addr = a;     v.rdy = rdy; v.rl = rl;       v.full = f;
      v.ack   = ack; v.av  = av;  v.araddr = ara; v.wr  = wr;  v.wdata = wd;   v.out = out;
      v.busy  = busy;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] a_b2b[5];
   logic        got;

   initial begin
      rst_n      = 1'b0;
      miss_req   = 1'b0;
      miss_addr  = '0;
      mem_arready = 1'b0;
      mem_rvalid = 1'b0;
      mem_rready = 1'b0;
      mem_rlast  = 1'b0;
      fifo_full  = 1'b0;

      //            r  q  addr           rdy rl f   ack av araddr        wr wdata         out busy
      // single miss, arready high
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0,  0, 0, 32'h0,         0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 1, 32'h0000_1238, 1, 0, 0,  1, 0, 32'h0,         0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 0, 32'hDEAD_BEEF, 1, 0, 0,  0, 1, 32'h0000_1238, 1, 32'h0000_1238, 0, 1));
      vecs.push_back(mk(1, 0, 32'hFFFF_FFF8, 1, 0, 0,  0, 0, 32'h0,         0, 32'h0,         1, 1));
      // arready low for 5 cycles, unaligned address
      vecs.push_back(mk(1, 1, 32'h8000_00AC, 0, 0, 0,  1, 0, 32'h0,         0, 32'h0,         1, 1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0,  0, 1, 32'h8000_00A8, 0, 32'h0,         1, 1));
      vecs.push_back(mk(1, 0, 32'h0,         1, 0, 0,  0, 1, 32'h8000_00A8, 1, 32'h8000_00AC, 1, 1));
      vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0,  0, 0, 32'h0,         0, 32'h0,         2, 1));
      // AR handshake coinciding with rlast at outstanding 2, then drain past zero
      vecs.push_back(mk(1, 1, 32'h0000_2000, 1, 0, 0,  1, 0, 32'h0,         0, 32'h0,         2, 1));
      vecs.push_back(mk(1, 0, 32'h0,         1, 1, 0,  0, 1, 32'h0000_2000, 1, 32'h0000_2000, 2, 1));
      vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0,  0, 0, 32'h0,         0, 32'h0,         2, 1));
      vecs.push_back(mk(1, 0, 32'h0,         0, 1, 0,  0, 0, 32'h0,         0, 32'h0,         2, 1));
      vecs.push_back(mk(1, 0, 32'h0,         0, 1, 0,  0, 0, 32'h0,         0, 32'h0,         1, 1));
      vecs.push_back(mk(1, 0, 32'h0,         0, 1, 0,  0, 0, 32'h0,         0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0,  0, 0, 32'h0,         0, 32'h0,         0, 0));
      // FIFO full blocks capture for 3 cycles
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1, 1, 32'h0000_3000, 1, 0, 1, 0, 0, 32'h0,        0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 1, 32'h0000_3000, 1, 0, 0,  1, 0, 32'h0,         0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 0, 32'h0,         1, 0, 0,  0, 1, 32'h0000_3000, 1, 32'h0000_3000, 0, 1));
      vecs.push_back(mk(1, 0, 32'h0,         0, 1, 0,  0, 0, 32'h0,         0, 32'h0,         1, 1));
      vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0,  0, 0, 32'h0,         0, 32'h0,         0, 0));
      // reset while ISSUE with one burst in flight, then a stray rlast
      vecs.push_back(mk(1, 1, 32'h0000_4000, 1, 0, 0,  1, 0, 32'h0,         0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 0, 32'h0,         1, 0, 0,  0, 1, 32'h0000_4000, 1, 32'h0000_4000, 0, 1));
      vecs.push_back(mk(1, 1, 32'h0000_5008, 0, 0, 0,  1, 0, 32'h0,         0, 32'h0,         1, 1));
      vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0,  0, 1, 32'h0000_5008, 0, 32'h0,         1, 1));
      vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0,  0, 1, 32'h0000_5008, 0, 32'h0,         1, 1));
      vecs.push_back(mk(1, 0, 32'h0,         1, 0, 0,  0, 0, 32'h0,         0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 0, 32'h0,         0, 1, 0,  0, 0, 32'h0,         0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0,  0, 0, 32'h0,         0, 32'h0,         0, 0));

      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         rst_n       = vecs[i].rst_n;
         miss_req    = vecs[i].req;
         miss_addr   = vecs[i].addr;
         mem_arready = vecs[i].rdy;
         mem_rvalid  = vecs[i].rl;
         mem_rready  = vecs[i].rl;
         mem_rlast   = vecs[i].rl;
         fifo_full   = vecs[i].full;
         #3;
         check_eq($sformatf("v%0d ack", i), {31'd0, miss_ack_o}, {31'd0, vecs[i].ack});
         check_eq($sformatf("v%0d arvalid", i), {31'd0, mem_arvalid_o}, {31'd0, vecs[i].av});
         check_eq($sformatf("v%0d wren", i), {31'd0, miss_addr_fifo_wren_o},
                  {31'd0, vecs[i].wr});
         check_eq($sformatf("v%0d outstanding", i), {29'd0, outstanding_o}, {29'd0, vecs[i].out});
         check_eq($sformatf("v%0d busy", i), {31'd0, busy_o}, {31'd0, vecs[i].busy});
         if (vecs[i].av) check_eq($sformatf("v%0d araddr", i), mem_araddr_o, vecs[i].araddr);
         if (vecs[i].wr) check_eq($sformatf("v%0d wdata", i), miss_addr_fifo_wdata_o,
                                  vecs[i].wdata);
         step();
      end

      // Five back-to-back misses against a limit of four, no rlast until the fifth stalls.
      rst_n       = 1'b1;
      mem_arready = 1'b1;
      mem_rvalid  = 1'b0;
      mem_rready  = 1'b0;
      mem_rlast   = 1'b0;
      fifo_full   = 1'b0;
      push_q.delete();
      for (int k = 0; k < 5; k++) a_b2b[k] = 32'h0001_0004 + 32'(k) * 32'h40;

      for (int k = 0; k < 5; k++) begin
         miss_req  = 1'b1;
         miss_addr = a_b2b[k];
         got       = 1'b0;
         for (int c = 0; c < 6 && !got; c++) begin
            #3;
            if (miss_ack_o === 1'b1) got = 1'b1;
            step();
         end
         if (k < 4) begin
            check_eq($sformatf("b2b miss%0d acked", k), {31'd0, got}, 32'd1);
            miss_req = 1'b0;
         end else begin
            check_eq("b2b miss4 held off", {31'd0, got}, 32'd0);
         end
      end
      #3;
      check_eq("b2b outstanding at limit", {29'd0, outstanding_o}, 32'd4);
      step();
      mem_rvalid = 1'b1;
      mem_rready = 1'b1;
      mem_rlast  = 1'b1;
      #3;
      check_eq("b2b no ack during rlast", {31'd0, miss_ack_o}, 32'd0);
      step();
      mem_rvalid = 1'b0;
      mem_rready = 1'b0;
      mem_rlast  = 1'b0;
      #3;
      check_eq("b2b ack after rlast", {31'd0, miss_ack_o}, 32'd1);
      step();
      miss_req = 1'b0;
      #3;
      check_eq("b2b miss4 arvalid", {31'd0, mem_arvalid_o}, 32'd1);
      check_eq("b2b miss4 wren", {31'd0, miss_addr_fifo_wren_o}, 32'd1);
      check_eq("b2b miss4 araddr", mem_araddr_o, 32'h0001_0100);
      step();
      #3;
      check_eq("b2b outstanding final", {29'd0, outstanding_o}, 32'd4);
      check_eq("b2b push count", push_q.size(), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < push_q.size()) check_eq($sformatf("b2b push order %0d", k), push_q[k], a_b2b[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/cc_miss_req_ctrl.md
CC_MISS_REQ_CTRL -- requirements
Module: cc_miss_req_ctrl

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, maximum in-flight read bursts (legal range 1..7).
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 miss_req_i  input  1  miss request from tag compare; held until acked.
REQ-005 miss_addr_i  input  32  byte address of the missing word.
REQ-006 miss_ack_o  output  1  one-cycle pulse: request captured.
REQ-007 mem_arvalid_o  output  1  AXI AR valid.
REQ-008 mem_arready_i  input  1  AXI AR ready.
REQ-009 mem_araddr_o  output  32  AXI AR address.
REQ-010 mem_arlen_o  output  4  burst length minus one.
REQ-011 mem_arsize_o  output  3  beat size code.
REQ-012 mem_arburst_o  output  2  burst type.
REQ-013 mem_rvalid_i, mem_rready_i, mem_rlast_i  input  1 each  R-channel monitor.
REQ-014 miss_addr_fifo_full_i  input  1  miss address FIFO full.
REQ-015 miss_addr_fifo_wren_o  output  1  FIFO push strobe.
REQ-016 miss_addr_fifo_wdata_o  output  32  FIFO push data.
REQ-017 outstanding_o  output  3  current in-flight burst count.
REQ-018 busy_o  output  1  high when state != IDLE or outstanding_o != 0.

Function
REQ-019 FSM states SHALL be IDLE and ISSUE only.
REQ-020 IDLE->ISSUE SHALL occur when miss_req_i=1, outstanding_o<MAX_OUTSTANDING and miss_addr_fifo_full_i=0; miss_ack_o=1 that cycle and miss_addr_i SHALL be captured.
REQ-021 In IDLE with any capture condition false, miss_ack_o SHALL be 0 and state SHALL hold.
REQ-022 In ISSUE, mem_arvalid_o SHALL be 1 (registered, no comb path from inputs) and SHALL stay 1 with stable AR fields until mem_arready_i=1.
REQ-023 AR handshake (arvalid&arready) SHALL return FSM to IDLE; next capture earliest the following cycle (max one AR per 2 cycles).
REQ-024 mem_araddr_o SHALL be {captured[31:3],3'b000} (critical-word-first).
REQ-025 mem_arlen_o SHALL be 4'd7, mem_arsize_o 3'd3, mem_arburst_o 2'b10 (WRAP), constant.
REQ-026 miss_addr_fifo_wren_o SHALL pulse exactly in the AR handshake cycle, wdata = full captured address, preserving AR order in FIFO.
REQ-027 outstanding SHALL +1 on AR handshake, -1 on mem_rvalid_i&mem_rready_i&mem_rlast_i, unchanged when both occur same cycle.
REQ-028 Decrement at outstanding=0 SHALL be ignored (no underflow wrap); increment SHALL never exceed MAX_OUTSTANDING by construction of REQ-020.
REQ-029 FIFO full is checked only at capture; block is the FIFO's sole writer so full cannot newly assert before the push.
REQ-030 miss_addr_i changes while miss_req_i=0 SHALL have no effect.

Reset
REQ-031 On rst_n=0 at a clock edge: state=IDLE, outstanding=0, captured address=0, all valid/strobe/ack outputs 0.
REQ-032 Reset mid-ISSUE SHALL drop mem_arvalid_o next cycle with no FIFO push; in-flight R beats after reset SHALL not decrement below 0.

Structure
REQ-033 Shared package cc_pkg SHALL hold the state enum, AXI burst-type constants (BURST_WRAP=2'b10), CC_BURST_LEN=7, CC_BEAT_SIZE=3.
REQ-034 Single flat module; no sub-module, outstanding counter inline.

Verification
REQ-035 Single miss addr 0x0000_1238, arready tied 1 -> ack cycle N, arvalid cycle N+1, araddr 0x0000_1238, FIFO push 0x0000_1238 same cycle, outstanding 1.
REQ-036 arready held 0 for 5 cycles -> arvalid and araddr stable 5 cycles, one push only on the handshake.
REQ-037 Five back-to-back misses, MAX_OUTSTANDING=4, no rlast -> 4 ARs issued, 5th not acked until one rlast beat, then issued.
REQ-038 AR handshake and rlast in same cycle at outstanding=2 -> outstanding stays 2.
REQ-039 miss_addr_fifo_full_i=1 with miss_req_i=1 for 3 cycles -> no ack, no AR; full drops -> ack next cycle.
REQ-040 rst_n asserted during ISSUE -> arvalid 0, outstanding 0, no push; stray rlast -> outstanding stays 0.
